// File: rtl/gate_access_arbiter.sv
// Shares one gate between entry and exit requesters: edge-latched requests,
// round-robin on contention, entry authorisation timeout and occupancy tracking.
module gate_access_arbiter #(
  parameter int CAPACITY     = 4,
  parameter int OPEN_CYCLES  = 8,
  parameter int AUTH_TIMEOUT = 16,
  parameter int DENY_CYCLES  = 4,
  localparam int CW          = $clog2(CAPACITY + 1)
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          REQ_IN,
  input  logic          REQ_OUT,
  input  logic          AUTH,
  output logic          GATE_OPEN,
  output logic          GRANT_IN,
  output logic          GRANT_OUT,
  output logic          DENY,
  output logic [CW-1:0] COUNT,
  output logic [6:0]    HEX0
);

  localparam int TMAX_A = (OPEN_CYCLES > AUTH_TIMEOUT) ? OPEN_CYCLES : AUTH_TIMEOUT;
  localparam int TMAX   = (TMAX_A > DENY_CYCLES) ? TMAX_A : DENY_CYCLES;
  localparam int TW     = $clog2(TMAX + 1);

  localparam logic [CW-1:0] FULL   = CW'(CAPACITY);
  localparam logic [TW-1:0] T_OPEN = TW'(OPEN_CYCLES - 1);
  localparam logic [TW-1:0] T_AUTH = TW'(AUTH_TIMEOUT - 1);
  localparam logic [TW-1:0] T_DENY = TW'(DENY_CYCLES - 1);

  localparam logic [6:0] HEX_BLANK = 7'b1111111;
  localparam logic [6:0] HEX_E     = 7'b0110000;
  localparam logic [6:0] HEX_S     = 7'b0100100;
  localparam logic [6:0] HEX_DASH  = 7'b1111110;
  localparam logic [6:0] HEX_F     = 7'b0111000;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_AUTH, S_OPEN_IN, S_OPEN_OUT, S_DENY
  } state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic [CW-1:0] count, count_nxt;
  logic          req_in_q, req_out_q;
  logic          pend_in, pend_out;
  logic          rr_exit_first, rr_nxt;
  logic          serve_in, serve_out;
  logic          timer_zero;

  // A fresh edge is taken straight from the pin so pend is set on the sampling edge.
  wire rise_in  = REQ_IN  & ~req_in_q;
  wire rise_out = REQ_OUT & ~req_out_q;

  assign timer_zero = (timer == '0);
  assign COUNT      = count;

  function automatic logic [6:0] hex_for(input state_t s, input logic [CW-1:0] c);
    case (s)
      S_WAIT_AUTH, S_OPEN_IN: hex_for = HEX_E;
      S_OPEN_OUT:             hex_for = HEX_S;
      S_DENY:                 hex_for = HEX_DASH;
      default:                hex_for = (c == FULL) ? HEX_F : HEX_BLANK;
    endcase
  endfunction

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_nxt = state;
    timer_nxt = timer;
    count_nxt = count;
    rr_nxt    = rr_exit_first;
    serve_in  = 1'b0;
    serve_out = 1'b0;
    case (state)
      S_IDLE: begin
        if (pend_in && pend_out) begin
          serve_out = rr_exit_first;
          serve_in  = ~rr_exit_first;
          rr_nxt    = ~rr_exit_first;
        end else begin
          serve_in  = pend_in;
          serve_out = pend_out;
        end
        if (serve_in) begin
          state_nxt = (count == FULL) ? S_DENY : S_WAIT_AUTH;
          timer_nxt = (count == FULL) ? T_DENY : T_AUTH;
        end else if (serve_out) begin
          state_nxt = (count == '0) ? S_DENY : S_OPEN_OUT;
          timer_nxt = (count == '0) ? T_DENY : T_OPEN;
        end
      end
      S_WAIT_AUTH: begin
        if (AUTH) begin
          state_nxt = S_OPEN_IN;
          timer_nxt = T_OPEN;
        end else if (timer_zero) begin
          state_nxt = S_DENY;
          timer_nxt = T_DENY;
        end else begin
          timer_nxt = timer - TW'(1);
        end
      end
      S_OPEN_IN, S_OPEN_OUT, S_DENY: begin
        if (timer_zero) begin
          state_nxt = S_IDLE;
          if (state == S_OPEN_IN && count != FULL) count_nxt = count + CW'(1);
          if (state == S_OPEN_OUT && count != '0)  count_nxt = count - CW'(1);
        end else begin
          timer_nxt = timer - TW'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they are registered yet track the current state.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state         <= S_IDLE;
      timer         <= '0;
      count         <= '0;
      req_in_q      <= 1'b0;
      req_out_q     <= 1'b0;
      pend_in       <= 1'b0;
      pend_out      <= 1'b0;
      rr_exit_first <= 1'b1;
      GATE_OPEN     <= 1'b0;
      GRANT_IN      <= 1'b0;
      GRANT_OUT     <= 1'b0;
      DENY          <= 1'b0;
      HEX0          <= HEX_BLANK;
    end else begin
      state         <= state_nxt;
      timer         <= timer_nxt;
      count         <= count_nxt;
      req_in_q      <= REQ_IN;
      req_out_q     <= REQ_OUT;
      pend_in       <= rise_in  | (pend_in  & ~serve_in);
      pend_out      <= rise_out | (pend_out & ~serve_out);
      rr_exit_first <= rr_nxt;
      GATE_OPEN     <= (state_nxt == S_OPEN_IN) || (state_nxt == S_OPEN_OUT);
      GRANT_IN      <= (state_nxt == S_OPEN_IN);
      GRANT_OUT     <= (state_nxt == S_OPEN_OUT);
      DENY          <= (state_nxt == S_DENY);
      HEX0          <= hex_for(state_nxt, count_nxt);
    end
  end

endmodule
